// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types and message-size helpers for the imem/dmem memory-port arbiter.
// Message layout: {type(1), addr, len, data} for requests and {type(1), len, data} for responses.
package riscv_mem_arbiter_pkg;

    typedef enum logic {
        REQ_IMEM = 1'b0,
        REQ_DMEM = 1'b1
    } req_id_e;

    // Reset to dmem so that imem wins the first tie.
    localparam req_id_e c_last_grant_rst = REQ_DMEM;

    function automatic int unsigned mem_len_sz(input int unsigned data_sz);
        return (data_sz > 8) ? $clog2(data_sz / 8) : 1;
    endfunction

    function automatic int unsigned mem_req_msg_sz(input int unsigned addr_sz,
                                                   input int unsigned data_sz);
        return 1 + addr_sz + mem_len_sz(data_sz) + data_sz;
    endfunction

    function automatic int unsigned mem_resp_msg_sz(input int unsigned data_sz);
        return 1 + mem_len_sz(data_sz) + data_sz;
    endfunction

endpackage

// File: rtl/riscv_mem_arb_idq.sv
// In-order owner-ID queue: one bit per outstanding memory request, no push/pop bypass.
module riscv_mem_arb_idq
    import riscv_mem_arbiter_pkg::*;
#(
    parameter int unsigned p_depth = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  logic push_id_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_id_o
);

    localparam int unsigned c_ptr_sz = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int unsigned c_cnt_sz = $clog2(p_depth) + 1;

    logic [p_depth-1:0]  ids_q,   ids_d;
    logic [c_ptr_sz-1:0] head_q,  head_d;
    logic [c_ptr_sz-1:0] tail_q,  tail_d;
    logic [c_cnt_sz-1:0] count_q, count_d;
    logic                do_push;
    logic                do_pop;

    // Full/empty come from the registered count only, so a pop never frees a slot in its own cycle.
    always_comb begin
        full_o    = (count_q == c_cnt_sz'(p_depth));
        empty_o   = (count_q == '0);
        head_id_o = ids_q[head_q];
        do_push   = push_i & ~full_o;
        do_pop    = pop_i & ~empty_o;

        ids_d   = ids_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (do_push) begin
            ids_d[tail_q] = push_id_i;
            tail_d        = tail_q + c_ptr_sz'(1);
        end
        if (do_pop) begin
            head_d = head_q + c_ptr_sz'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + c_cnt_sz'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - c_cnt_sz'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ids_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ids_q   <= ids_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the imem (0) and dmem (1) ports;
// responses return in request order and are routed by the owner-ID queue.
module riscv_mem_arbiter
    import riscv_mem_arbiter_pkg::*;
#(
    parameter  int unsigned p_addr_sz = 32,
    parameter  int unsigned p_data_sz = 32,
    parameter  int unsigned p_max_out = 4,
    localparam int unsigned c_req_sz  = mem_req_msg_sz(p_addr_sz, p_data_sz),
    localparam int unsigned c_resp_sz = mem_resp_msg_sz(p_data_sz),
    localparam int unsigned c_cnt_sz  = $clog2(p_max_out) + 1
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic [c_req_sz-1:0]  req0_msg,
    input  logic                 req0_val,
    output logic                 req0_rdy,
    output logic [c_resp_sz-1:0] resp0_msg,
    output logic                 resp0_val,

    input  logic [c_req_sz-1:0]  req1_msg,
    input  logic                 req1_val,
    output logic                 req1_rdy,
    output logic [c_resp_sz-1:0] resp1_msg,
    output logic                 resp1_val,

    output logic [c_req_sz-1:0]  memreq_msg,
    output logic                 memreq_val,
    input  logic                 memreq_rdy,
    input  logic [c_resp_sz-1:0] memresp_msg,
    input  logic                 memresp_val,

    output logic                 err
);

    req_id_e grant_id;
    req_id_e last_grant_q;
    logic    err_q;
    logic    fire;
    logic    pop;
    logic    q_full;
    logic    q_empty;
    logic    q_head_id;

    riscv_mem_arb_idq #(
        .p_depth (p_max_out)
    ) u_idq (
        .clk       (clk),
        .reset     (reset),
        .push_i    (fire),
        .push_id_i (grant_id),
        .pop_i     (pop),
        .full_o    (q_full),
        .empty_o   (q_empty),
        .head_id_o (q_head_id)
    );

    // Grant, forwarding and response routing are all zero-latency; reset forces every output low.
    always_comb begin
        grant_id = REQ_IMEM;
        if (req0_val && req1_val) begin
            grant_id = (last_grant_q == REQ_IMEM) ? REQ_DMEM : REQ_IMEM;
        end else if (req1_val) begin
            grant_id = REQ_DMEM;
        end

        memreq_val = ~reset & (req0_val | req1_val) & ~q_full;
        memreq_msg = '0;
        if (memreq_val) begin
            memreq_msg = (grant_id == REQ_DMEM) ? req1_msg : req0_msg;
        end

        req0_rdy = memreq_val & (grant_id == REQ_IMEM) & memreq_rdy;
        req1_rdy = memreq_val & (grant_id == REQ_DMEM) & memreq_rdy;
        fire     = memreq_val & memreq_rdy;

        pop       = ~reset & memresp_val & ~q_empty;
        resp0_val = pop & ~q_head_id;
        resp1_val = pop & q_head_id;
        resp0_msg = reset ? '0 : memresp_msg;
        resp1_msg = reset ? '0 : memresp_msg;

        err = err_q;
    end

    // A response with nothing outstanding is a protocol error that latches until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= c_last_grant_rst;
            err_q        <= 1'b0;
        end else begin
            if (fire) begin
                last_grant_q <= grant_id;
            end
            if (memresp_val && q_empty) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule
